// File: rtl/ls_pkg.sv
// Load/store shared definitions: size codes, FSM
// states and the alignment rule used by both paths.
package ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } ls_state_e;

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       sext;
  } ld_cmd_t;

  // Any size code other than byte/half is a word
  function automatic logic is_misaligned(
    input logic [1:0] off,
    input logic [1:0] size
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): r = 1'b0;
      (size == SZ_HALF): r = off[0];
      default:           r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian byte/half/word extraction with
// sign or zero extension of a 32-bit read word.
module load_extract
  import ls_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_offset)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_offset[1] ? i_rdata[31:16]
                              : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_data = {{24{i_sext & w_byte[7]}}, w_byte};
      (i_size == SZ_HALF):
        o_data = {{16{i_sext & w_half[15]}}, w_half};
      default:
        o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Multi-cycle load engine: one aligned word read,
// then extract/extend into a register-file value.
module load_align_unit
  import ls_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [31:0] Addr,
  input  logic [1:0]  Bytes2Load,
  input  logic        SignExt,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  ls_state_e   r_state;
  ls_state_e   w_next;
  ld_cmd_t     r_cmd;
  logic [7:0]  r_cnt;
  logic [31:0] r_mem_addr;
  logic [31:0] r_load_data;
  logic        r_mis;
  logic        r_to;
  logic        w_mis;
  logic        w_to_hit;
  logic [31:0] w_ext;

  assign w_mis    = is_misaligned(Addr[1:0], Bytes2Load);
  assign w_to_hit = (r_cnt + 8'd1) == TO_LIM;

  load_extract u_extract (
    .i_rdata  (MemRData),
    .i_offset (r_cmd.off),
    .i_size   (r_cmd.size),
    .i_sext   (r_cmd.sext),
    .o_data   (w_ext)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (Start) w_next = w_mis ? ST_DONE : ST_REQ;
      ST_REQ:
        if (MemAck || w_to_hit) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_load_data <= '0;
      r_mis       <= 1'b0;
      r_to        <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: if (Start) begin
          r_cmd.off  <= Addr[1:0];
          r_cmd.size <= Bytes2Load;
          r_cmd.sext <= SignExt;
          r_cnt      <= '0;
          r_mis      <= w_mis;
          r_to       <= 1'b0;
          if (w_mis) r_load_data <= '0;
          else r_mem_addr <= {Addr[31:2], 2'b00};
        end
        ST_REQ: if (MemAck) begin
          r_load_data <= w_ext;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          if (w_to_hit) begin
            r_to        <= 1'b1;
            r_load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign MemReq      = (r_state == ST_REQ);
  assign MemAddr     = r_mem_addr;
  assign Busy        = (r_state != ST_IDLE);
  assign Done        = (r_state == ST_DONE);
  assign LoadData    = r_load_data;
  assign MisalignErr = Done & r_mis;
  assign TimeoutErr  = Done & r_to;

endmodule
